host_packet_read: RTL and testbench
===================================

HOST_PACKET_READ -- requirements
Module: host_packet_read

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 2, packet-buffer read latency in cycles, legal 1..3.
REQ-002 SHALL have port i_clk  in  1  sole clock.
REQ-003 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port iv_descriptor  in  23  descriptor: [22:9] flow meta, [8:0] bufid.
REQ-005 SHALL have port i_descriptor_wr  in  1  descriptor valid, one-cycle pulse.
REQ-006 SHALL have port o_descriptor_ready  out  1  block can accept a descriptor.
REQ-007 SHALL have port ov_pkt_raddr  out  16  buffer read address {bufid, line[6:0]}.
REQ-008 SHALL have port o_pkt_rd  out  1  buffer read strobe.
REQ-009 SHALL have port iv_pkt_rdata  in  134  read data, [133:132] header (01 head, 11 body, 10 tail), RD_LATENCY cycles after o_pkt_rd.
REQ-010 SHALL have port i_fifo_alfull  in  1  downstream almost-full, asserted with at least RD_LATENCY+1 free entries.
REQ-011 SHALL have port ov_data  out  134  packet line to downstream FIFO.
REQ-012 SHALL have port o_data_wr  out  1  line valid.
REQ-013 SHALL have port ov_bufid_release  out  9  bufid to free.
REQ-014 SHALL have port o_bufid_release_wr  out  1  release request, held until ack.
REQ-015 SHALL have port i_bufid_release_ack  in  1  release accepted.
REQ-016 SHALL have port o_pkt_err  out  1  one-cycle pulse on truncated packet.

Function
REQ-017 SHALL implement FSM IDLE, READ, DRAIN, RELEASE.
REQ-018 IDLE: o_descriptor_ready=1; i_descriptor_wr at cycle T latches bufid, clears line counter, moves to READ at T+1. Ready is 0 in all other states.
REQ-019 READ: o_pkt_rd=1 and ov_pkt_raddr={bufid,line} each cycle i_fifo_alfull=0; line increments per read. When i_fifo_alfull=1, no read is issued and line is held.
REQ-020 Return pipeline: a shift register of depth RD_LATENCY tracks in-flight reads. Each valid return is registered to ov_data/o_data_wr one cycle later; first o_data_wr occurs at T+1+RD_LATENCY+1 with no stall.
REQ-021 On a valid return with header 10 (tail): stop issuing reads, go to DRAIN. In-flight returns behind the tail SHALL be discarded, with no o_data_wr.
REQ-022 Line cap: after 128 reads without a tail, stop issuing. If the 128th return is not a tail, forward it with header forced to 10, pulse o_pkt_err with that o_data_wr, and go to DRAIN.
REQ-023 DRAIN: wait until the in-flight pipeline is empty, then go to RELEASE.
REQ-024 RELEASE: drive o_bufid_release_wr=1 with the latched ov_bufid_release. On i_bufid_release_ack, deassert next cycle and go to IDLE. A new descriptor is acceptable one cycle after ack.
REQ-025 i_descriptor_wr while ready=0 SHALL be ignored; the upstream guarantees it does not occur.
REQ-026 Line counter is 8 bits, with no wrap beyond 128.

Reset
REQ-027 i_rst asserted asynchronously forces IDLE, clears the pipeline, counters and the latched bufid.
REQ-028 During reset, outputs are o_descriptor_ready=0, o_pkt_rd=0, o_data_wr=0, o_bufid_release_wr=0, o_pkt_err=0, and all vectors are 0. o_descriptor_ready rises the first cycle after reset deasserts.
REQ-029 Reset mid-packet abandons the packet, and its bufid is not released.

Configuration
REQ-030 Macro HOST_PKT_READ_CNT_EN: when defined, add output ov_tx_pkt_cnt (32 bits), incremented on each release ack, wrapping at 2^32-1 to 0, reset to 0. When undefined, the port and counter are absent, with no other behavioural change.

Verification
REQ-031 Descriptor bufid=5, 4-line packet, no stall: reads at addresses 0x0280..0x0283; 4 o_data_wr starting at T+4; release bufid 5; ready=1 after ack.
REQ-032 i_fifo_alfull held high for 3 cycles mid-packet: reads pause exactly 3 cycles, no line is lost or duplicated, and data order is preserved.
REQ-033 Tail at line 1 with 2 reads in flight: exactly 2 o_data_wr, extra returns are dropped, release follows.
REQ-034 128 body lines with no tail: 128 o_data_wr, the last with header 10, o_pkt_err pulses once, bufid is released.
REQ-035 Ack delayed 5 cycles: release_wr is held 5 cycles and ready stays 0. Reset asserted in READ: all outputs are 0 immediately, and no release occurs.
REQ-036 HOST_PKT_READ_CNT_EN defined, 3 packets sent: ov_tx_pkt_cnt=3.

Source files
------------

// File: rtl/host_packet_read.sv
// Host packet reader: fetches a descriptor's buffer lines, forwards them downstream, then frees the bufid.
// Optional HOST_PKT_READ_CNT_EN adds ov_tx_pkt_cnt, a count of released packets.
module host_packet_read #(
  parameter int RD_LATENCY = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [22:0]  iv_descriptor,
  input  logic         i_descriptor_wr,
  output logic         o_descriptor_ready,
  output logic [15:0]  ov_pkt_raddr,
  output logic         o_pkt_rd,
  input  logic [133:0] iv_pkt_rdata,
  input  logic         i_fifo_alfull,
  output logic [133:0] ov_data,
  output logic         o_data_wr,
  output logic [8:0]   ov_bufid_release,
  output logic         o_bufid_release_wr,
  input  logic         i_bufid_release_ack,
  output logic         o_pkt_err
`ifdef HOST_PKT_READ_CNT_EN
  ,
  output logic [31:0]  ov_tx_pkt_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_DRAIN   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] LINE_CAP = 8'd128;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  function automatic logic is_tail(input logic [1:0] hdr);
    return (hdr == HDR_TAIL);
  endfunction

  state_t                r_state;
  logic [8:0]            r_bufid;
  logic [7:0]            r_line;
  logic [7:0]            r_ret_cnt;
  logic [RD_LATENCY-1:0] r_inflight;
  logic                  r_pkt_rd;
  logic [15:0]           r_pkt_raddr;
  logic [133:0]          r_data;
  logic                  r_data_wr;
  logic                  r_release_wr;
  logic                  r_ready;
  logic                  r_pkt_err;
`ifdef HOST_PKT_READ_CNT_EN
  logic [31:0]           r_tx_pkt_cnt;
`endif

  logic [RD_LATENCY-1:0] w_inflight_next;
  logic                  w_ret_vld;
  logic                  w_ret_tail;
  logic                  w_ret_last;
  logic                  w_cap_hit;
  logic                  w_stop;
  logic                  w_can_issue;
  logic                  w_pipe_empty;
  logic                  w_unused_meta;

  // Bit k of r_inflight marks a read issued k+1 cycles ago; the top bit qualifies iv_pkt_rdata.
  if (RD_LATENCY == 1) begin : g_pipe_one
    assign w_inflight_next = r_pkt_rd;
  end else begin : g_pipe_multi
    assign w_inflight_next = {r_inflight[RD_LATENCY-2:0], r_pkt_rd};
  end

  assign w_ret_vld     = r_inflight[RD_LATENCY-1];
  assign w_ret_tail    = is_tail(iv_pkt_rdata[133:132]);
  assign w_ret_last    = (r_ret_cnt == (LINE_CAP - 8'd1));
  assign w_cap_hit     = w_ret_vld && !w_ret_tail && w_ret_last;
  assign w_stop        = w_ret_vld && (w_ret_tail || w_ret_last);
  assign w_can_issue   = (r_line < LINE_CAP) && !i_fifo_alfull;
  assign w_pipe_empty  = (r_inflight == {RD_LATENCY{1'b0}}) && !r_pkt_rd;
  assign w_unused_meta = ^iv_descriptor[22:9];

  // Packet-read FSM; every output is registered here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_bufid      <= 9'd0;
      r_line       <= 8'd0;
      r_ret_cnt    <= 8'd0;
      r_inflight   <= {RD_LATENCY{1'b0}};
      r_pkt_rd     <= 1'b0;
      r_pkt_raddr  <= 16'd0;
      r_data       <= 134'd0;
      r_data_wr    <= 1'b0;
      r_release_wr <= 1'b0;
      r_ready      <= 1'b0;
      r_pkt_err    <= 1'b0;
`ifdef HOST_PKT_READ_CNT_EN
      r_tx_pkt_cnt <= 32'd0;
`endif
    end else begin
      r_inflight <= w_inflight_next;
      r_pkt_rd   <= 1'b0;
      r_data_wr  <= 1'b0;
      r_pkt_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_descriptor_wr && r_ready) begin
            // The first read goes out in the first READ cycle, hence issued from here.
            r_bufid     <= iv_descriptor[8:0];
            r_ret_cnt   <= 8'd0;
            r_ready     <= 1'b0;
            r_state     <= S_READ;
            r_pkt_raddr <= {iv_descriptor[8:0], 7'd0};
            if (i_fifo_alfull) begin
              r_line   <= 8'd0;
              r_pkt_rd <= 1'b0;
            end else begin
              r_line   <= 8'd1;
              r_pkt_rd <= 1'b1;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_READ: begin
          if (w_ret_vld) begin
            r_data_wr <= 1'b1;
            r_ret_cnt <= r_ret_cnt + 8'd1;
            r_pkt_err <= w_cap_hit;
            if (w_cap_hit) begin
              r_data <= {HDR_TAIL, iv_pkt_rdata[131:0]};
            end else begin
              r_data <= iv_pkt_rdata;
            end
          end else begin
            r_data <= r_data;
          end
          if (w_stop) begin
            r_state <= S_DRAIN;
          end else if (w_can_issue) begin
            r_pkt_rd    <= 1'b1;
            r_pkt_raddr <= {r_bufid, r_line[6:0]};
            r_line      <= r_line + 8'd1;
          end else begin
            r_line <= r_line;
          end
        end
        S_DRAIN: begin
          // Returns still in flight behind the last forwarded line are dropped here.
          if (w_pipe_empty) begin
            r_release_wr <= 1'b1;
            r_state      <= S_RELEASE;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_RELEASE: begin
          if (i_bufid_release_ack) begin
            r_release_wr <= 1'b0;
            r_ready      <= 1'b1;
            r_state      <= S_IDLE;
`ifdef HOST_PKT_READ_CNT_EN
            r_tx_pkt_cnt <= r_tx_pkt_cnt + 32'd1;
`endif
          end else begin
            r_release_wr <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_release_wr <= 1'b0;
          r_ready      <= 1'b0;
        end
      endcase
    end
  end

  assign o_descriptor_ready = r_ready;
  assign ov_pkt_raddr       = r_pkt_raddr;
  assign o_pkt_rd           = r_pkt_rd;
  assign ov_data            = r_data;
  assign o_data_wr          = r_data_wr;
  assign ov_bufid_release   = r_bufid;
  assign o_bufid_release_wr = r_release_wr;
  assign o_pkt_err          = r_pkt_err;
`ifdef HOST_PKT_READ_CNT_EN
  assign ov_tx_pkt_cnt      = r_tx_pkt_cnt;
`endif

endmodule

// File: tb/tb_host_packet_read.sv
// Bench for host_packet_read: a buffer memory model answers reads, and each packet's downstream
// stream, read addresses, error pulse and release handshake are compared with a reference.
module tb_host_packet_read;

  localparam int RD_LAT = 2;

  logic         i_clk;
  logic         i_rst;
  logic [22:0]  iv_descriptor;
  logic         i_descriptor_wr;
  logic         o_descriptor_ready;
  logic [15:0]  ov_pkt_raddr;
  logic         o_pkt_rd;
  logic [133:0] iv_pkt_rdata;
  logic         i_fifo_alfull;
  logic [133:0] ov_data;
  logic         o_data_wr;
  logic [8:0]   ov_bufid_release;
  logic         o_bufid_release_wr;
  logic         i_bufid_release_ack;
  logic         o_pkt_err;
`ifdef HOST_PKT_READ_CNT_EN
  logic [31:0]  ov_tx_pkt_cnt;
`endif

  host_packet_read #(.RD_LATENCY(RD_LAT)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .iv_descriptor      (iv_descriptor),
    .i_descriptor_wr    (i_descriptor_wr),
    .o_descriptor_ready (o_descriptor_ready),
    .ov_pkt_raddr       (ov_pkt_raddr),
    .o_pkt_rd           (o_pkt_rd),
    .iv_pkt_rdata       (iv_pkt_rdata),
    .i_fifo_alfull      (i_fifo_alfull),
    .ov_data            (ov_data),
    .o_data_wr          (o_data_wr),
    .ov_bufid_release   (ov_bufid_release),
    .o_bufid_release_wr (o_bufid_release_wr),
    .i_bufid_release_ack(i_bufid_release_ack),
    .o_pkt_err          (o_pkt_err)
`ifdef HOST_PKT_READ_CNT_EN
    ,
    .ov_tx_pkt_cnt      (ov_tx_pkt_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acked = 0;

  logic [133:0] pkt_mem [0:127];
  logic [15:0]  rd_addr_q [$];
  int           rd_cyc_q [$];
  logic [133:0] wr_q [$];
  int           wr_cyc_q [$];
  logic         err_q [$];
  int           rel_cycles = 0;
  int           stray_err = 0;
  logic         hv [0:3];
  logic [15:0]  ha [0:3];

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial forever begin
    @(posedge i_clk);
    cyc = cyc + 1;
  end

  function automatic logic [133:0] rand134();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[133:0];
  endfunction

  // Buffer memory: a read seen in cycle c is answered during cycle c+RD_LAT; otherwise random junk.
  initial begin
    for (int k = 0; k < 4; k++) begin
      hv[k] = 1'b0;
      ha[k] = 16'd0;
    end
    iv_pkt_rdata = 134'd0;
    forever begin
      @(negedge i_clk);
      for (int k = 3; k > 0; k--) begin
        hv[k] = hv[k-1];
        ha[k] = ha[k-1];
      end
      hv[0] = o_pkt_rd && !i_rst;
      ha[0] = ov_pkt_raddr;
      if (i_rst) begin
        for (int k = 0; k < 4; k++) hv[k] = 1'b0;
      end
      if (hv[RD_LAT]) iv_pkt_rdata = pkt_mem[ha[RD_LAT][6:0]];
      else            iv_pkt_rdata = rand134();
    end
  end

  // Recorder for reads, forwarded lines, error pulses and release cycles.
  initial forever begin
    @(negedge i_clk);
    if (!i_rst) begin
      if (o_pkt_rd) begin
        rd_addr_q.push_back(ov_pkt_raddr);
        rd_cyc_q.push_back(cyc);
      end
      if (o_data_wr) begin
        wr_q.push_back(ov_data);
        wr_cyc_q.push_back(cyc);
        err_q.push_back(o_pkt_err);
      end
      if (o_pkt_err && !o_data_wr) stray_err = stray_err + 1;
      if (o_bufid_release_wr) rel_cycles = rel_cycles + 1;
    end
  end

  task automatic check_v(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // len 1..128 puts the tail at line len-1; len 0 builds 128 body lines with no tail.
  task automatic make_pkt(input int len);
    logic [133:0] d;
    for (int i = 0; i < 128; i++) begin
      d = rand134();
      d[133:132] = (i == 0) ? 2'b01 : 2'b11;
      if (len > 0 && i == len - 1)  d[133:132] = 2'b10;
      else if (len > 0 && i >= len) d[133:132] = 2'($urandom_range(0, 3));
      pkt_mem[i] = d;
    end
  endtask

  task automatic clear_rec();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    wr_q.delete();
    wr_cyc_q.delete();
    err_q.delete();
    rel_cycles = 0;
    stray_err  = 0;
  endtask

  task automatic send_desc(input logic [8:0] bufid, output int t_desc);
    int w;
    w = 0;
    while (!o_descriptor_ready && w < 50) begin
      @(negedge i_clk);
      w++;
    end
    check_i("desc_ready", int'(o_descriptor_ready), 1);
    iv_descriptor   = {14'($urandom()), bufid};
    i_descriptor_wr = 1'b1;
    t_desc          = cyc;
    @(negedge i_clk);
    i_descriptor_wr = 1'b0;
    check_i("ready_low_after_desc", int'(o_descriptor_ready), 0);
  endtask

  // stall: 0 none, 1 alfull for exactly 3 cycles from T+3, 2 random alfull.
  task automatic run_pkt(input logic [8:0] bufid, input int len, input int ack_d, input int stall);
    int t_desc, w, n_exp, hi, ne, gap;
    bit found, exp_err;
    logic [133:0] ev;
    make_pkt(len);
    clear_rec();
    send_desc(bufid, t_desc);
    w = 0;
    while (!o_bufid_release_wr && w < 600) begin
      case (stall)
        1:       i_fifo_alfull = (cyc >= t_desc + 3) && (cyc <= t_desc + 5);
        2:       i_fifo_alfull = ($urandom_range(0, 3) == 0);
        default: i_fifo_alfull = 1'b0;
      endcase
      @(negedge i_clk);
      w++;
    end
    i_fifo_alfull = 1'b0;
    check_i("release_seen", int'(o_bufid_release_wr), 1);
    check_v("release_bufid", 134'(ov_bufid_release), 134'(bufid));
    for (int k = 1; k < ack_d; k++) begin
      check_i("release_hold", int'(o_bufid_release_wr), 1);
      check_i("ready_low_in_release", int'(o_descriptor_ready), 0);
      @(negedge i_clk);
    end
    i_bufid_release_ack = 1'b1;
    @(negedge i_clk);
    i_bufid_release_ack = 1'b0;
    n_acked++;
    check_i("release_drop", int'(o_bufid_release_wr), 0);
    check_i("ready_after_ack", int'(o_descriptor_ready), 1);
    check_i("release_cycles", rel_cycles, ack_d);
`ifdef HOST_PKT_READ_CNT_EN
    check_i("tx_pkt_cnt", int'(ov_tx_pkt_cnt), n_acked);
`endif
    // Reference: the packet ends at its first tail line, or is cut at line 127.
    found = 1'b0;
    n_exp = 128;
    for (int i = 0; i < 128; i++) begin
      if (!found && pkt_mem[i][133:132] == 2'b10) begin
        found = 1'b1;
        n_exp = i + 1;
      end
    end
    exp_err = !found;
    check_i("wr_count", wr_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < wr_q.size(); i++) begin
      ev = pkt_mem[i];
      if (exp_err && i == n_exp - 1) ev[133:132] = 2'b10;
      check_v("line_data", wr_q[i], ev);
    end
    ne = 0;
    foreach (err_q[i]) if (err_q[i]) ne++;
    check_i("err_pulses", ne, exp_err ? 1 : 0);
    if (exp_err && wr_q.size() == n_exp) check_i("err_on_last", int'(err_q[n_exp-1]), 1);
    check_i("stray_err", stray_err, 0);
    hi = (n_exp + RD_LAT > 128) ? 128 : n_exp + RD_LAT;
    check_i("rd_count_in_range", int'(rd_addr_q.size() >= n_exp && rd_addr_q.size() <= hi), 1);
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      check_v("rd_addr", 134'(rd_addr_q[i]), 134'({bufid, 7'(i)}));
    end
    if (stall == 0 && wr_cyc_q.size() > 0) check_i("first_wr_cycle", wr_cyc_q[0], t_desc + RD_LAT + 2);
    if (stall == 1 && rd_cyc_q.size() > 0) begin
      gap = (rd_cyc_q[$] - rd_cyc_q[0] + 1) - rd_cyc_q.size();
      check_i("stall_gap", gap, 3);
    end
  endtask

  initial begin
    int t_desc;
    i_rst               = 1'b1;
    iv_descriptor       = 23'd0;
    i_descriptor_wr     = 1'b0;
    i_fifo_alfull       = 1'b0;
    i_bufid_release_ack = 1'b0;
    for (int i = 0; i < 128; i++) pkt_mem[i] = 134'd0;

    repeat (3) @(negedge i_clk);
    check_i("rst_flags", int'({o_descriptor_ready, o_pkt_rd, o_data_wr, o_bufid_release_wr, o_pkt_err}), 0);
    check_v("rst_data", ov_data, 134'd0);
    check_v("rst_raddr", 134'(ov_pkt_raddr), 134'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check_i("ready_after_rst", int'(o_descriptor_ready), 1);

    // bufid 5, 4-line packet, no stall.
    run_pkt(9'd5, 4, 1, 0);
    check_v("raddr_first", 134'(rd_addr_q[0]), 134'(16'h0280));
    check_v("raddr_fourth", 134'(rd_addr_q[3]), 134'(16'h0283));
    // 3-cycle alfull mid-packet.
    run_pkt(9'($urandom_range(0, 511)), 10, 2, 1);
    // Tail at line 1 with reads in flight; ack delayed 5 cycles.
    run_pkt(9'($urandom_range(0, 511)), 2, 5, 0);
    // 128 body lines with no tail, then tail exactly at line 127.
    run_pkt(9'h1ff, 0, 1, 0);
    run_pkt(9'h100, 128, 1, 0);
    // Random packets.
    for (int p = 0; p < 6; p++) begin
      run_pkt(9'($urandom_range(0, 511)), int'($urandom_range(1, 24)), int'($urandom_range(1, 4)),
              ($urandom_range(0, 1) == 1) ? 2 : 0);
    end

    // Reset while reading abandons the packet without a release.
    make_pkt(100);
    clear_rec();
    send_desc(9'd7, t_desc);
    repeat (3) @(negedge i_clk);
    check_i("pre_rst_rd", int'(o_pkt_rd), 1);
    #2 i_rst = 1'b1;
    #1;
    check_i("midrst_flags", int'({o_descriptor_ready, o_pkt_rd, o_data_wr, o_bufid_release_wr, o_pkt_err}), 0);
    check_v("midrst_raddr", 134'(ov_pkt_raddr), 134'd0);
    check_v("midrst_bufid", 134'(ov_bufid_release), 134'd0);
    check_v("midrst_data", ov_data, 134'd0);
    clear_rec();
    @(negedge i_clk);
    i_rst = 1'b0;
    n_acked = 0;
    @(negedge i_clk);
    check_i("ready_after_midrst", int'(o_descriptor_ready), 1);
    repeat (30) @(negedge i_clk);
    check_i("no_release_after_rst", rel_cycles, 0);
    check_i("no_data_after_rst", wr_q.size(), 0);
    check_i("no_read_after_rst", rd_addr_q.size(), 0);
`ifdef HOST_PKT_READ_CNT_EN
    check_i("cnt_cleared", int'(ov_tx_pkt_cnt), 0);
`endif
    run_pkt(9'($urandom_range(0, 511)), 6, 2, 2);
    run_pkt(9'($urandom_range(0, 511)), 3, 1, 0);
    run_pkt(9'($urandom_range(0, 511)), 5, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
